gemm_stream_tx: RTL and testbench
=================================

# gemm_stream_tx

Frame transmitter for the GEMM engines. It buffers one operand vector written as packed 4-lane words and streams it element by element on the `gvalid`/`ivalid`/`in` serial interface that the GEMM engines consume. It holds the frame open until the engine returns its result on `ovalid`/`out`, then captures that result and closes the frame by dropping `gvalid`, which clears the engine. It sits between the RL controller and each GEMM stage.

## Interface
- `WIDTH`, 16, element width (fp16 bit pattern, never interpreted).
- `DEPTH`, 256, elements per frame; must be a multiple of 4 and at least 4. The buffer holds DEPTH/4 words.
- `TIMEOUT`, 1023, maximum number of WAIT cycles before the frame is aborted; must be at least 1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wvalid`  in  1  buffer write strobe.
- `wdata`  in  4*WIDTH  packed word; lane 3 `[4W-1:3W]` is transmitted first, lane 0 `[W-1:0]` last.
- `wready`  out  1  write accepted this cycle.
- `start`  in  1  request to transmit the buffered frame.
- `busy`  out  1  high in SEND, WAIT and DONE.
- `gvalid`  out  1  frame enable to the engine.
- `ivalid`  out  1  element strobe to the engine.
- `dout`  out  WIDTH  element to the engine.
- `rvalid`  in  1  engine result strobe (engine `ovalid`).
- `rdata`  in  WIDTH  engine result (engine `out`).
- `done`  out  1  one-cycle pulse when a frame closes.
- `result`  out  WIDTH  last captured result; held until the next capture.
- `timeout`  out  1  level; set when a frame aborts, cleared when the next `start` is accepted.

## Operation
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - `wready = (wcnt != DEPTH/4)`.
  - A write (`wvalid && wready`) stores `wdata` at index `wcnt` and increments `wcnt`.
  - `start` is accepted only when `wcnt == DEPTH/4`. Acceptance enters SEND, clears `rcnt`, `lane` and `timeout`.
  - `start` with a partial buffer is ignored; no state change.
- SEND:
  - Each cycle, `dout` = lane (3-`lane`) of `buf[rcnt]`, with `ivalid=1` and `gvalid=1`.
  - `lane` counts 0 to 3 (2 bits); on `lane==3`, `rcnt` increments.
  - After element DEPTH-1 is sent, go to WAIT.
- WAIT:
  - `gvalid=1`, `ivalid=0`, `dout` holds its last value. `tcnt` increments each cycle.
  - `rvalid=1`: capture `rdata` into `result`, go to DONE.
  - Otherwise, when `tcnt == TIMEOUT-1`: set `timeout`, go to DONE with `result` unchanged.
  - If `rvalid` and the timeout coincide, `rvalid` wins and `timeout` stays 0.
- DONE (1 cycle):
  - `gvalid=0`, `done=1`, `wcnt` cleared. Next state is IDLE.
  - The buffer must be reloaded before the next `start`.
- Signals ignored by state:
  - `wvalid` outside IDLE, or with a full buffer: ignored, `wready=0`.
  - `start` outside IDLE: ignored.
  - `rvalid` outside WAIT: ignored.
- Reset, including mid-frame:
  - State goes to IDLE; `wcnt`, `rcnt`, `lane`, `tcnt` are cleared.
  - Outputs `gvalid`, `ivalid`, `dout`, `done`, `result`, `timeout`, `busy` are 0; `wready=0` while `rst` is high.
  - Buffer contents are not reset, but are unreachable until rewritten.
  - Dropping `gvalid` on reset also clears the downstream engine.

## Timing
- `gvalid`, `ivalid`, `dout`, `done`, `result` and `timeout` are registered. `wready` and `busy` are decoded from the state.
- `start` accepted at edge t:
  - `gvalid=ivalid=1` with element 0 from t+1.
  - Element k is on `dout` at t+1+k; the last element is at t+DEPTH.
  - WAIT begins at t+DEPTH+1.
- `ivalid` is contiguous for exactly DEPTH cycles, with no bubbles.
- `rvalid` sampled in WAIT at edge r:
  - `result` is updated at r+1.
  - `done=1` and `gvalid=0` during cycle r+1.
  - IDLE at r+2, where `wready=1` again.
- Timeout: with no `rvalid`, `done` and `timeout` go high TIMEOUT cycles after WAIT entry.
- The minimum gap between frames is DEPTH/4 write cycles plus the `start` cycle.

## Test plan
1. DEPTH=8: write words 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005, then pulse `start`. Required:
   - `dout` = 4,3,2,1,8,7,6,5 on 8 consecutive `ivalid` cycles with `gvalid=1`.
   - `rvalid` with 0x3C00 three cycles later gives `result=0x3C00`, a one-cycle `done`, `gvalid=0`, then `wready=1`.
2. DEPTH=8: write one word, pulse `start`. Required: stays IDLE, `gvalid=0`, `wready=1`. Then write a second word, at which point `wready=0`, and a third `wvalid` is not stored. `start` then streams the first two words only.
3. DEPTH=8, TIMEOUT=15, no `rvalid`. Required:
   - `done` and `timeout` go to 1 exactly 15 cycles after WAIT entry; `result` keeps its prior value.
   - The next accepted `start` clears `timeout`.
4. Ignored inputs. Required: `rvalid` pulsed during SEND, and `start`/`wvalid` pulsed during WAIT, all have no effect; the stream and the final `result` are identical to scenario 1.
5. Assert `rst` at element 5 of SEND. Required:
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release, `wready=1`, and `start` without a reload is ignored.
6. Same-cycle `rvalid` and timeout expiry with `rdata=0xBC00`. Required: `result=0xBC00`, `timeout=0`, one `done` pulse.

Source files
------------

// File: rtl/gemm_stream_tx_if.sv
// Bundle of the write, control and engine-side serial signals of gemm_stream_tx.
// The master modport is the transmitter; the slave modport is the controller/engine side.
interface gemm_stream_tx_if #(
    parameter int WIDTH = 16
);
    logic                 wvalid;
    logic [4*WIDTH-1:0]   wdata;
    logic                 wready;
    logic                 start;
    logic                 busy;
    logic                 gvalid;
    logic                 ivalid;
    logic [WIDTH-1:0]     dout;
    logic                 rvalid;
    logic [WIDTH-1:0]     rdata;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic                 timeout;

    modport master (
        input  wvalid, wdata, start, rvalid, rdata,
        output wready, busy, gvalid, ivalid, dout, done, result, timeout
    );

    modport slave (
        output wvalid, wdata, start, rvalid, rdata,
        input  wready, busy, gvalid, ivalid, dout, done, result, timeout
    );
endinterface

// File: rtl/gemm_stream_tx.sv
// Buffers one frame of packed 4-lane words, streams it element by element to a GEMM
// engine, then waits (bounded) for the engine result and closes the frame.
module gemm_stream_tx #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    gemm_stream_tx_if.master bus
);
    localparam int NW  = DEPTH / 4;
    localparam int WCW = $clog2(NW + 1);
    localparam int RW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WCW-1:0]     wcnt_q, wcnt_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    logic [1:0]         lane_q, lane_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               gvalid_q, gvalid_d;
    logic               ivalid_q, ivalid_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               timeout_q, timeout_d;

    logic [4*WIDTH-1:0] mem_q [NW];

    logic               full_s;
    logic               wready_s;
    logic               wr_en_s;
    logic               last_s;
    logic [RW-1:0]      nxt_rcnt_s;
    logic [1:0]         nxt_lane_s;

    // Lane counter 0 selects the most significant element, which goes out first.
    function automatic logic [WIDTH-1:0] lane_sel(input logic [4*WIDTH-1:0] word,
                                                  input logic [1:0]         lane);
        case (lane)
            2'd0:    lane_sel = word[4*WIDTH-1:3*WIDTH];
            2'd1:    lane_sel = word[3*WIDTH-1:2*WIDTH];
            2'd2:    lane_sel = word[2*WIDTH-1:WIDTH];
            default: lane_sel = word[WIDTH-1:0];
        endcase
    endfunction

    assign full_s     = (wcnt_q == WCW'(NW));
    assign wready_s   = !rst && (state_q == S_IDLE) && !full_s;
    assign wr_en_s    = bus.wvalid && wready_s;
    assign last_s     = (rcnt_q == RW'(NW - 1)) && (lane_q == 2'd3);
    assign nxt_lane_s = lane_q + 2'd1;
    assign nxt_rcnt_s = (lane_q == 2'd3) ? (rcnt_q + RW'(1)) : rcnt_q;

    // Next-state and registered-output decode; outputs are computed one cycle ahead.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        lane_d    = lane_q;
        tcnt_d    = tcnt_q;
        gvalid_d  = gvalid_q;
        ivalid_d  = ivalid_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        result_d  = result_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (wr_en_s) begin
                    wcnt_d = wcnt_q + WCW'(1);
                end else begin
                    wcnt_d = wcnt_q;
                end
                if (bus.start && full_s) begin
                    state_d   = S_SEND;
                    rcnt_d    = '0;
                    lane_d    = 2'd0;
                    timeout_d = 1'b0;
                    gvalid_d  = 1'b1;
                    ivalid_d  = 1'b1;
                    dout_d    = lane_sel(mem_q[0], 2'd0);
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SEND: begin
                if (last_s) begin
                    state_d  = S_WAIT;
                    ivalid_d = 1'b0;
                    tcnt_d   = '0;
                end else begin
                    rcnt_d   = nxt_rcnt_s;
                    lane_d   = nxt_lane_s;
                    dout_d   = lane_sel(mem_q[nxt_rcnt_s], nxt_lane_s);
                end
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still counts as a result.
                if (bus.rvalid) begin
                    result_d = bus.rdata;
                    done_d   = 1'b1;
                    gvalid_d = 1'b0;
                    state_d  = S_DONE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    gvalid_d  = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    tcnt_d    = tcnt_q + TW'(1);
                end
            end
            S_DONE: begin
                wcnt_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            lane_q    <= 2'd0;
            tcnt_q    <= '0;
            gvalid_q  <= 1'b0;
            ivalid_q  <= 1'b0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            lane_q    <= lane_d;
            tcnt_q    <= tcnt_d;
            gvalid_q  <= gvalid_d;
            ivalid_q  <= ivalid_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    // Frame buffer; not reset, a frame is only reachable once wcnt reaches NW again.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wcnt_q[RW-1:0]] <= bus.wdata;
        end
    end

    assign bus.wready  = wready_s;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.gvalid  = gvalid_q;
    assign bus.ivalid  = ivalid_q;
    assign bus.dout    = dout_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_gemm_stream_tx.sv
// Randomized scoreboard bench for gemm_stream_tx with DEPTH=8, TIMEOUT=15.
module tb_gemm_stream_tx;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 15;
    localparam int NW      = DEPTH / 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    gemm_stream_tx_if #(.WIDTH(WIDTH)) bus ();

    gemm_stream_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: words in the buffer, expected element stream, expected frame closes.
    logic [4*WIDTH-1:0] model_words [$];
    logic [WIDTH-1:0]   exp_stream  [$];
    logic [WIDTH:0]     exp_done    [$];
    logic [WIDTH-1:0]   model_result;
    logic [WIDTH:0]     mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every element strobe and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ivalid) begin
                if (exp_stream.size() == 0) chk("unexpected_ivalid", 64'd1, 64'd0);
                else chk("dout", bus.dout, exp_stream.pop_front());
            end
            if (bus.done) begin
                if (exp_done.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                else begin
                    mon_e = exp_done.pop_front();
                    chk("result", bus.result, mon_e[WIDTH-1:0]);
                    chk("timeout_flag", bus.timeout, mon_e[WIDTH]);
                end
            end
        end
    end

    // Called at a negedge in IDLE; returns at the following negedge.
    task automatic write_word(input logic [4*WIDTH-1:0] w);
        bus.wvalid = 1'b1;
        bus.wdata  = w;
        chk("wready", bus.wready, (model_words.size() < NW) ? 64'd1 : 64'd0);
        if (model_words.size() < NW) model_words.push_back(w);
        @(negedge clk);
        bus.wvalid = 1'b0;
    endtask

    task automatic load_random();
        for (int i = 0; i < NW; i++) write_word({$urandom, $urandom});
    endtask

    task automatic push_stream();
        logic [4*WIDTH-1:0] w;
        for (int i = 0; i < model_words.size(); i++) begin
            w = model_words[i];
            for (int l = 3; l >= 0; l--) exp_stream.push_back(w[l*WIDTH +: WIDTH]);
        end
    endtask

    // rv_at: WAIT cycle index (0-based) whose closing edge samples rvalid; -1 means none.
    task automatic run_frame(input int rv_at, input logic [WIDTH-1:0] rd, input bit noise);
        logic [WIDTH-1:0] last_elem;
        bit               got;
        got = (rv_at >= 0) && (rv_at < TIMEOUT);
        push_stream();
        last_elem = exp_stream[exp_stream.size()-1];
        exp_done.push_back(got ? {1'b0, rd} : {1'b1, model_result});
        model_words.delete();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("first_gvalid", bus.gvalid, 64'd1);
        chk("first_ivalid", bus.ivalid, 64'd1);
        chk("start_clears_timeout", bus.timeout, 64'd0);
        chk("busy_send", bus.busy, 64'd1);
        for (int k = 1; k < DEPTH; k++) begin
            if (noise && k == 2) begin
                bus.rvalid = 1'b1;
                bus.rdata  = 16'hDEAD;
            end
            @(negedge clk);
            bus.rvalid = 1'b0;
            chk("ivalid_contig", bus.ivalid, 64'd1);
        end
        @(negedge clk);
        chk("wait_ivalid", bus.ivalid, 64'd0);
        chk("wait_gvalid", bus.gvalid, 64'd1);
        chk("wait_dout_hold", bus.dout, last_elem);
        for (int c = 0; c < TIMEOUT; c++) begin
            if (c == rv_at) begin
                bus.rvalid = 1'b1;
                bus.rdata  = rd;
            end
            if (noise && c == 0) begin
                bus.start  = 1'b1;
                bus.wvalid = 1'b1;
                bus.wdata  = {$urandom, $urandom};
            end
            @(negedge clk);
            bus.rvalid = 1'b0;
            bus.start  = 1'b0;
            bus.wvalid = 1'b0;
            if (c == rv_at) break;
            if (c < TIMEOUT - 1) chk("no_early_done", bus.done, 64'd0);
        end
        chk("done_pulse", bus.done, 64'd1);
        chk("done_gvalid", bus.gvalid, 64'd0);
        if (got) model_result = rd;
        @(negedge clk);
        chk("done_one_cycle", bus.done, 64'd0);
        chk("idle_wready", bus.wready, 64'd1);
        chk("idle_busy", bus.busy, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.wvalid = 1'b0;
        bus.wdata  = '0;
        bus.start  = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        model_result = '0;
        #2;
        chk("rst_gvalid", bus.gvalid, 64'd0);
        chk("rst_ivalid", bus.ivalid, 64'd0);
        chk("rst_done", bus.done, 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_timeout", bus.timeout, 64'd0);
        chk("rst_busy", bus.busy, 64'd0);
        chk("rst_wready", bus.wready, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fixed frame with the known element order.
        write_word(64'h0004_0003_0002_0001);
        write_word(64'h0008_0007_0006_0005);
        run_frame(2, 16'h3C00, 1'b0);

        // Partial buffer: start ignored, third write dropped.
        write_word({$urandom, $urandom});
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("partial_gvalid", bus.gvalid, 64'd0);
        chk("partial_busy", bus.busy, 64'd0);
        chk("partial_wready", bus.wready, 64'd1);
        write_word({$urandom, $urandom});
        write_word({$urandom, $urandom});
        run_frame(4, 16'h1234, 1'b0);

        // Timeout with no result; result must be kept and timeout held until the next start.
        load_random();
        run_frame(-1, 16'h0000, 1'b0);
        chk("timeout_level", bus.timeout, 64'd1);
        chk("timeout_result_kept", bus.result, 64'h1234);

        // Ignored inputs in SEND and WAIT on the scenario-1 frame.
        write_word(64'h0004_0003_0002_0001);
        write_word(64'h0008_0007_0006_0005);
        run_frame(2, 16'h3C00, 1'b1);

        // Reset in the middle of SEND.
        load_random();
        push_stream();
        model_words.delete();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_gvalid", bus.gvalid, 64'd0);
        chk("midrst_ivalid", bus.ivalid, 64'd0);
        chk("midrst_dout", bus.dout, 64'd0);
        chk("midrst_done", bus.done, 64'd0);
        chk("midrst_result", bus.result, 64'd0);
        chk("midrst_timeout", bus.timeout, 64'd0);
        chk("midrst_busy", bus.busy, 64'd0);
        chk("midrst_wready", bus.wready, 64'd0);
        exp_stream.delete();
        exp_done.delete();
        model_result = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_wready", bus.wready, 64'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("postrst_start_ignored", bus.gvalid, 64'd0);
        chk("postrst_busy", bus.busy, 64'd0);

        // Result on the same cycle the wait expires.
        load_random();
        run_frame(TIMEOUT - 1, 16'hBC00, 1'b0);

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            load_random();
            run_frame(int'($urandom_range(0, TIMEOUT - 1)), 16'($urandom), 1'b0);
        end

        chk("stream_drained", exp_stream.size(), 64'd0);
        chk("done_drained", exp_done.size(), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
